controle_varredura: RTL and testbench

- Sequencer for the servo PWM block (position counter plus PWM generator) in a sonar-style sweep.
- Loads a start position, waits for the servo to settle, and requests a distance measurement.
- Then requests serial transmission of the result and steps the servo one position.
- Sweep is ping-pong (0→3→0→…). The block is the sole driver of the PWM block's set_pos/direita/esquerda/pos_inicial inputs and reads its pos output as feedback.

---
 rtl/controle_varredura.sv | 136 +++++++++++++
 tb/tb_controle_varredura.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/controle_varredura.sv
// Sweep sequencer for the servo PWM block: positions the servo, waits for it to
// settle, triggers a distance measurement, sends the result over serial and
// steps the servo one position, bouncing between positions 0 and 3.
module controle_varredura #(
  parameter int unsigned T_ACOMODA   = 25_000_000,
  parameter int unsigned T_TIMEOUT   = 5_000_000,
  parameter logic [1:0]  POS_INICIAL = 2'b00
) (
  input  logic       clock,
  input  logic       zera,
  input  logic       ligar,
  input  logic [1:0] pos,
  input  logic       fim_medida,
  input  logic       fim_transmissao,
  output logic       set_pos,
  output logic [1:0] pos_inicial,
  output logic       direita,
  output logic       esquerda,
  output logic       medir,
  output logic       transmitir,
  output logic       sentido,
  output logic       erro_medida,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL       = 4'd0,
    POSICIONA     = 4'd1,
    ACOMODA       = 4'd2,
    INICIA_MEDIDA = 4'd3,
    ESPERA_MEDIDA = 4'd4,
    INICIA_TX     = 4'd5,
    ESPERA_TX     = 4'd6,
    PROXIMA       = 4'd7
  } estado_t;

  localparam logic [31:0] ACOMODA_FIM = 32'(T_ACOMODA - 1);
  localparam logic [31:0] TIMEOUT_FIM = 32'(T_TIMEOUT - 1);

  estado_t     estado, estado_next;
  logic [31:0] contador;
  logic        sentido_next;
  logic        erro_next;

  assign pos_inicial = POS_INICIAL;
  assign db_estado   = estado;

  // State register plus the direction and error flags updated by the FSM
  always_ff @(posedge clock or posedge zera) begin
    if (zera) begin
      estado      <= INICIAL;
      sentido     <= 1'b0;
      erro_medida <= 1'b0;
    end else begin
      estado      <= estado_next;
      sentido     <= sentido_next;
      erro_medida <= erro_next;
    end
  end

  // Shared settle/timeout counter, cleared whenever the state changes
  always_ff @(posedge clock or posedge zera) begin
    if (zera)
      contador <= '0;
    else if (estado_next != estado)
      contador <= '0;
    else
      contador <= contador + 32'd1;
  end

  // Next-state and pulse decode; the step pulse in PROXIMA depends on the
  // fed-back position so the reversal happens on the same cycle as the step
  always_comb begin
    estado_next  = estado;
    sentido_next = sentido;
    erro_next    = erro_medida;
    set_pos      = 1'b0;
    direita      = 1'b0;
    esquerda     = 1'b0;
    medir        = 1'b0;
    transmitir   = 1'b0;
    case (estado)
      INICIAL: begin
        if (ligar) estado_next = POSICIONA;
      end
      POSICIONA: begin
        set_pos      = 1'b1;
        sentido_next = (POS_INICIAL == 2'd3);
        erro_next    = 1'b0;
        estado_next  = ACOMODA;
      end
      ACOMODA: begin
        if (contador == ACOMODA_FIM) estado_next = INICIA_MEDIDA;
      end
      INICIA_MEDIDA: begin
        medir       = 1'b1;
        estado_next = ESPERA_MEDIDA;
      end
      ESPERA_MEDIDA: begin
        if (fim_medida) begin
          estado_next = INICIA_TX;
        end else if (contador == TIMEOUT_FIM) begin
          erro_next   = 1'b1;
          estado_next = PROXIMA;
        end
      end
      INICIA_TX: begin
        transmitir  = 1'b1;
        estado_next = ESPERA_TX;
      end
      ESPERA_TX: begin
        if (fim_transmissao) estado_next = PROXIMA;
      end
      PROXIMA: begin
        if (!ligar) begin
          estado_next = INICIAL;
        end else begin
          estado_next = ACOMODA;
          if (!sentido && pos == 2'd3) begin
            sentido_next = 1'b1;
            esquerda     = 1'b1;
          end else if (sentido && pos == 2'd0) begin
            sentido_next = 1'b0;
            direita      = 1'b1;
          end else if (!sentido) begin
            direita = 1'b1;
          end else begin
            esquerda = 1'b1;
          end
        end
      end
      default: estado_next = INICIAL;
    endcase
  end

endmodule

// File: tb/tb_controle_varredura.sv
// Directed bench for controle_varredura with a behavioural servo position
// model and delayed responders for the sensor and serial interfaces.
module tb_controle_varredura;

  logic       clock = 1'b0;
  logic       zera = 1'b1;
  logic       ligar = 1'b0;
  logic [1:0] pos = 2'b00;
  logic       fim_medida = 1'b0;
  logic       fim_transmissao = 1'b0;
  logic       set_pos, direita, esquerda, medir, transmitir, sentido, erro_medida;
  logic [1:0] pos_inicial;
  logic [3:0] db_estado;

  int total = 0;
  int bad = 0;
  int med_delay = 3;
  int tx_delay = 3;

  controle_varredura #(
    .T_ACOMODA(10),
    .T_TIMEOUT(20),
    .POS_INICIAL(2'b00)
  ) dut (
    .clock(clock),
    .zera(zera),
    .ligar(ligar),
    .pos(pos),
    .fim_medida(fim_medida),
    .fim_transmissao(fim_transmissao),
    .set_pos(set_pos),
    .pos_inicial(pos_inicial),
    .direita(direita),
    .esquerda(esquerda),
    .medir(medir),
    .transmitir(transmitir),
    .sentido(sentido),
    .erro_medida(erro_medida),
    .db_estado(db_estado)
  );

  initial forever #5 clock = ~clock;

  // Servo position model
  always @(posedge clock) begin
    if (set_pos) pos <= pos_inicial;
    else if (direita && pos != 2'd3) pos <= pos + 2'd1;
    else if (esquerda && pos != 2'd0) pos <= pos - 2'd1;
  end

  // Sensor responder: fim_medida pulse med_delay cycles after medir
  initial forever begin
    @(negedge clock);
    if (medir && med_delay > 0) begin
      repeat (med_delay) @(negedge clock);
      fim_medida = 1'b1;
      @(negedge clock);
      fim_medida = 1'b0;
    end
  end

  // Serial responder: fim_transmissao pulse tx_delay cycles after transmitir
  initial forever begin
    @(negedge clock);
    if (transmitir && tx_delay > 0) begin
      repeat (tx_delay) @(negedge clock);
      fim_transmissao = 1'b1;
      @(negedge clock);
      fim_transmissao = 1'b0;
    end
  end

  task automatic test_reset_start();
    int n;
    zera = 1'b1;
    ligar = 1'b1;
    repeat (2) @(negedge clock);
    total++; if (db_estado !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", db_estado); end
    total++; if ({set_pos, direita, esquerda, medir, transmitir, sentido, erro_medida} !== 7'b0) begin
      bad++; $display("FAIL reset_outputs got=%b exp=0000000", {set_pos, direita, esquerda, medir, transmitir, sentido, erro_medida}); end
    total++; if (pos_inicial !== 2'b00) begin bad++; $display("FAIL pos_inicial got=%0d exp=0", pos_inicial); end
    zera = 1'b0;
    @(negedge clock);
    total++; if (db_estado !== 4'd1 || set_pos !== 1'b1) begin bad++; $display("FAIL posiciona got=%0d/%b exp=1/1", db_estado, set_pos); end
    @(negedge clock);
    total++; if (db_estado !== 4'd2 || set_pos !== 1'b0) begin bad++; $display("FAIL acomoda_entry got=%0d/%b exp=2/0", db_estado, set_pos); end
    n = 0;
    while (!medir && n < 50) begin @(negedge clock); n++; end
    total++; if (n !== 10 || db_estado !== 4'd3) begin bad++; $display("FAIL settle_time got=%0d/%0d exp=10/3", n, db_estado); end
  endtask

  task automatic test_sweep();
    logic exp_dir [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0] exp_pos [7] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1};
    logic exp_sent [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    int steps = 0, meds = 0, txs = 0, cyc = 0;
    while (steps < 7 && cyc < 1000) begin
      @(negedge clock); cyc++;
      if (medir) meds++;
      if (transmitir) txs++;
      if (direita || esquerda) begin
        total++; if (direita !== exp_dir[steps] || esquerda !== !exp_dir[steps]) begin
          bad++; $display("FAIL step_dir[%0d] got=%b%b exp=%b%b", steps, direita, esquerda, exp_dir[steps], !exp_dir[steps]); end
        @(negedge clock); cyc++;
        total++; if (pos !== exp_pos[steps] || sentido !== exp_sent[steps]) begin
          bad++; $display("FAIL step_pos[%0d] got=%0d/%b exp=%0d/%b", steps, pos, sentido, exp_pos[steps], exp_sent[steps]); end
        steps++;
      end
    end
    total++; if (steps !== 7 || meds !== 6 || txs !== 7 || erro_medida !== 1'b0) begin
      bad++; $display("FAIL sweep_counts got=%0d/%0d/%0d/%b exp=7/6/7/0", steps, meds, txs, erro_medida); end
  endtask

  task automatic test_timeout();
    int n = 0, w = 0;
    logic early = 1'b0, tx = 1'b0;
    med_delay = -1;
    while (!medir && w < 50) begin @(negedge clock); w++; end
    @(negedge clock);
    while (db_estado == 4'd4 && n < 100) begin
      n++;
      if (erro_medida) early = 1'b1;
      if (transmitir) tx = 1'b1;
      @(negedge clock);
    end
    total++; if (n !== 20 || early !== 1'b0) begin bad++; $display("FAIL timeout_len got=%0d/%b exp=20/0", n, early); end
    total++; if (db_estado !== 4'd7 || erro_medida !== 1'b1 || transmitir !== 1'b0 || tx !== 1'b0) begin
      bad++; $display("FAIL timeout_flag got=%0d/%b/%b exp=7/1/0", db_estado, erro_medida, tx); end
    total++; if (direita !== 1'b1 || esquerda !== 1'b0) begin bad++; $display("FAIL timeout_step got=%b%b exp=10", direita, esquerda); end
    med_delay = 3;
  endtask

  task automatic test_stop_restart();
    int w = 0;
    tx_delay = -1;
    while (db_estado != 4'd6 && w < 100) begin @(negedge clock); w++; end
    ligar = 1'b0;
    repeat (2) @(negedge clock);
    total++; if (db_estado !== 4'd6) begin bad++; $display("FAIL wait_tx got=%0d exp=6", db_estado); end
    fim_transmissao = 1'b1;
    @(negedge clock);
    fim_transmissao = 1'b0;
    total++; if (db_estado !== 4'd7 || direita !== 1'b0 || esquerda !== 1'b0) begin
      bad++; $display("FAIL stop_no_step got=%0d/%b%b exp=7/00", db_estado, direita, esquerda); end
    repeat (4) @(negedge clock);
    total++; if (db_estado !== 4'd0 || pos !== 2'd2 || erro_medida !== 1'b1) begin
      bad++; $display("FAIL stopped got=%0d/%0d/%b exp=0/2/1", db_estado, pos, erro_medida); end
    ligar = 1'b1;
    tx_delay = 3;
    @(negedge clock);
    total++; if (db_estado !== 4'd1 || set_pos !== 1'b1) begin bad++; $display("FAIL restart got=%0d/%b exp=1/1", db_estado, set_pos); end
    @(negedge clock);
    total++; if (db_estado !== 4'd2 || erro_medida !== 1'b0 || pos !== 2'd0 || sentido !== 1'b0) begin
      bad++; $display("FAIL restart_clear got=%0d/%b/%0d/%b exp=2/0/0/0", db_estado, erro_medida, pos, sentido); end
  endtask

  task automatic test_fim_on_timeout();
    int n = 0, w = 0;
    med_delay = 20;
    while (!medir && w < 50) begin @(negedge clock); w++; end
    @(negedge clock);
    while (db_estado == 4'd4 && n < 100) begin n++; @(negedge clock); end
    total++; if (n !== 20 || db_estado !== 4'd5 || transmitir !== 1'b1 || erro_medida !== 1'b0) begin
      bad++; $display("FAIL fim_wins got=%0d/%0d/%b/%b exp=20/5/1/0", n, db_estado, transmitir, erro_medida); end
    w = 0;
    while (db_estado != 4'd7 && w < 50) begin @(negedge clock); w++; end
    total++; if (db_estado !== 4'd7 || erro_medida !== 1'b0 || direita !== 1'b1) begin
      bad++; $display("FAIL fim_wins_step got=%0d/%b/%b exp=7/0/1", db_estado, erro_medida, direita); end
    med_delay = 3;
  endtask

  task automatic test_async_reset();
    int w = 0;
    while (!esquerda && w < 400) begin @(negedge clock); w++; end
    @(negedge clock);
    total++; if (db_estado !== 4'd2 || sentido !== 1'b1) begin bad++; $display("FAIL pre_reset got=%0d/%b exp=2/1", db_estado, sentido); end
    repeat (3) @(negedge clock);
    #2 zera = 1'b1;
    #1;
    total++; if (db_estado !== 4'd0 || {set_pos, direita, esquerda, medir, transmitir, sentido, erro_medida} !== 7'b0) begin
      bad++; $display("FAIL async_reset got=%0d/%b exp=0/0000000", db_estado,
                      {set_pos, direita, esquerda, medir, transmitir, sentido, erro_medida}); end
    ligar = 1'b0;
    @(negedge clock);
    zera = 1'b0;
    @(negedge clock);
    total++; if (db_estado !== 4'd0) begin bad++; $display("FAIL idle_after_reset got=%0d exp=0", db_estado); end
  endtask

  initial begin
    test_reset_start();
    test_sweep();
    test_timeout();
    test_stop_restart();
    test_fim_on_timeout();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
